mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port data memory (MemRead/MemWrite/Address/WriteData/ReadData, level-sensitive strobes, combinational read) between two requesters: port 0 = instruction fetch, port 1 = load/store unit.
- Sequences every access as setup → strobe → hold, so address and data are stable around each strobe and the two strobes never overlap.
- Returns read data and a one-cycle ack to the winning requester.
- Sits between the Mini MIPS control/datapath and the memory instance.

Parameters:
- ADDR_W, 32, address width passed unchanged to Address.
- DATA_W, 32, data width of WriteData/ReadData/wdataN/rdataN.
- ACCESS_CYCLES, 1, number of cycles a strobe is held (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port-0 request; held high until ack0.
- we0  in  1  port-0 write enable (0 = read).
- addr0  in  ADDR_W  port-0 address.
- wdata0  in  DATA_W  port-0 write data.
- ack0  out  1  port-0 completion pulse.
- rdata0  out  DATA_W  port-0 read data, registered.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- Address  out  ADDR_W  memory address.
- WriteData  out  DATA_W  memory write data.
- ReadData  in  DATA_W  memory read data (combinational from Address).

Behaviour:
- Reset: all outputs are 0, state = IDLE, last_grant = 1 (so port 0 wins the first tie), cycle counter = 0.
- Reset asserted mid-access: strobes, Address and WriteData drop to 0 at that edge, no ack is issued, and the memory contents are whatever the strobe already wrote.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port ≠ last_grant (round-robin).
  - On grant, latch gnt, we, addr and wdata; update last_grant; go to SETUP.
  - If no req is high, stay in IDLE.
- SETUP (1 cycle): Address and WriteData are driven from the latches; both strobes are 0; counter is loaded with ACCESS_CYCLES-1.
- ACCESS (ACCESS_CYCLES cycles):
  - Exactly one strobe is high: MemWrite if the latched we = 1, else MemRead.
  - Address and WriteData are held.
  - On a read, ReadData is captured into the granted port's rdata on the last ACCESS edge.
  - The counter decrements each cycle; exit to HOLD when the counter = 0.
- HOLD (1 cycle):
  - Both strobes are 0; Address and WriteData are still held.
  - ack of the granted port is 1 (Moore output) and that port's rdata is valid.
  - Next state is IDLE.
- Latency: with the req seen in IDLE at cycle n, ack is high in cycle n+2+ACCESS_CYCLES. With ACCESS_CYCLES = 1, that is ack in cycle n+3 and one access per 4 cycles.
- Handshake rules:
  - A requester holds req, we, addr and wdata stable from req rise until ack.
  - req must be low in the cycle after ack unless a new request is intended. A req still high in IDLE is treated as a new request.
  - Inputs from a non-granted port are ignored until its grant.
- rdata of the non-granted port is never modified. rdataN keeps its last value after a write access.
- Invariant: MemRead and MemWrite are never both 1, and neither is 1 in IDLE, SETUP or HOLD.
- Address is passed unmodified; the arbiter performs no alignment or bounds checking.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding: IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, HOLD = 2'd3;
  - port index constants: PORT_IF = 0, PORT_LS = 1.
- One sub-module, rr_arb2: a 2-input round-robin picker (req0, req1, last_grant → gnt, valid), purely combinational.
- The FSM, latches and counter stay in mem_arbiter.

Test Plan:
- Read, port 0 only:
  - Stimulus: after reset, preload word 3 = 32'h5555_5540; req0 = 1, we0 = 0, addr0 = 3.
  - Required: MemRead high in exactly cycle n+2; ack0 in cycle n+3; rdata0 = 32'h5555_5540; ack1 = 0 throughout.
- Write then read, port 1:
  - Stimulus: req1 with we1 = 1, addr1 = 7, wdata1 = 32'hDEAD_BEEF; after ack1, a read from addr 7.
  - Required: MemWrite high for exactly 1 cycle with Address = 7 stable in the SETUP through HOLD cycles; the following read returns rdata1 = 32'hDEAD_BEEF.
- Simultaneous requests:
  - Stimulus: req0 and req1 both held high continuously.
  - Required: grants alternate 0, 1, 0, 1 (port 0 first after reset); each ack is 4 cycles apart; no strobe overlap.
- ACCESS_CYCLES = 3:
  - Stimulus: a single read.
  - Required: MemRead high for 3 consecutive cycles; ack in cycle n+5.
- Reset mid-ACCESS:
  - Stimulus: reset = 1 during the strobe cycle of a write.
  - Required: at the next edge all outputs are 0 and state = IDLE; no ack issued; after release, port 0 wins a tie.
- Non-granted port isolation:
  - Stimulus: port 1 changes addr1 and wdata1 while port 0's access is in flight.
  - Required: Address and WriteData still show port 0's values; rdata1 is unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state encoding and port indices for the two-port memory arbiter.
// Ports: 0 = instruction fetch, 1 = load/store unit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker, purely combinational (zero latency).
// On a tie the port that did not win last time is chosen; valid is low when nobody requests.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      gnt = ~last_grant;
    end else if (req1) begin
      gnt = PORT_LS;
    end else begin
      gnt = PORT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data memory between fetch and load/store with setup/strobe/hold sequencing.
// Ack arrives 2+ACCESS_CYCLES cycles after a grant in IDLE; the losing port waits with req held.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t            state, state_next;
  logic              pick_gnt, pick_valid;
  logic              gnt_q, we_q, last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt;

  rr_arb2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .gnt        (pick_gnt),
    .valid      (pick_valid)
  );

  always_comb begin
    state_next = state;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    WriteData  = '0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_next = SETUP;
      end
      SETUP: begin
        Address    = addr_q;
        WriteData  = wdata_q;
        state_next = ACCESS;
      end
      ACCESS: begin
        Address   = addr_q;
        WriteData = wdata_q;
        MemRead   = ~we_q;
        MemWrite  = we_q;
        if (cnt == 4'd0) state_next = HOLD;
      end
      HOLD: begin
        Address    = addr_q;
        WriteData  = wdata_q;
        ack0       = (gnt_q == PORT_IF);
        ack1       = (gnt_q == PORT_LS);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_LS;
      gnt_q      <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_q      <= pick_gnt;
            last_grant <= pick_gnt;
            we_q       <= pick_gnt ? we1 : we0;
            addr_q     <= pick_gnt ? addr1 : addr0;
            wdata_q    <= pick_gnt ? wdata1 : wdata0;
          end
        end
        SETUP: cnt <= CNT_LOAD;
        ACCESS: begin
          if (cnt == 4'd0) begin
            // ReadData is combinational from Address, so the last strobe cycle carries valid data
            if (!we_q) begin
              if (gnt_q == PORT_LS) rdata1 <= ReadData;
              else                  rdata0 <= ReadData;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: arbitration order, read data and ack timing predicted from port-level rules.
// A second instance with ACCESS_CYCLES = 3 exercises the stretched strobe.
module tb_mem_arbiter;

  localparam int AC = 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, we0, req1, we1, ack0, ack1;
  logic [31:0] addr0, wdata0, addr1, wdata1, rdata0, rdata1;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData;

  logic        req3, ack3a, ack3b, mr3, mw3;
  logic [31:0] addr3, rd3a, rd3b, ad3, wd3, rdd3;

  logic [31:0] mem  [0:63];
  logic [31:0] mem3 [0:63];
  logic        pre_we;
  logic [5:0]  pre_a;
  logic [31:0] pre_d;

  logic [31:0] ref_mem [0:63];
  logic [31:0] m_rdata0, m_rdata1;
  int          m_last;
  op_t         op_q0[$], op_q1[$];
  exp_t        exp_q[$];

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  int  strobe_cnt = 0;
  int  last_strobe = -10;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(3)) u3 (
    .clk(clk), .reset(reset),
    .req0(req3), .we0(1'b0), .addr0(addr3), .wdata0(32'd0), .ack0(ack3a), .rdata0(rd3a),
    .req1(1'b0), .we1(1'b0), .addr1(32'd0), .wdata1(32'd0), .ack1(ack3b), .rdata1(rd3b),
    .MemRead(mr3), .MemWrite(mw3), .Address(ad3),
    .WriteData(wd3), .ReadData(rdd3)
  );

  assign ReadData = mem[Address[5:0]];
  assign rdd3     = mem3[ad3[5:0]];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_a]  <= pre_d;
      mem3[pre_a] <= pre_d;
    end else begin
      if (MemWrite) mem[Address[5:0]] <= WriteData;
      if (mw3)      mem3[ad3[5:0]]    <= wd3;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    if (i == 3) return 32'h5555_5540;
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and checks strobes against the in-flight entry
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      m_rdata0   = '0;
      m_rdata1   = '0;
      strobe_cnt = 0;
    end else if (mon_en) begin
      check("strobe_overlap", 32'(MemRead & MemWrite), 32'd0);
      if (exp_q.size() > 0 && cyc == exp_q[0].ack_cyc - AC - 1) begin
        check("setup_addr", Address, exp_q[0].addr);
        check("setup_strobe", 32'({MemRead, MemWrite}), 32'd0);
      end
      if (MemRead || MemWrite) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'({MemRead, MemWrite}), 32'd0);
        end else begin
          check("strobe_addr", Address, exp_q[0].addr);
          check("strobe_kind", 32'({MemRead, MemWrite}), exp_q[0].we ? 32'd1 : 32'd2);
          if (exp_q[0].we) check("strobe_wdata", WriteData, exp_q[0].data);
          strobe_cnt++;
          last_strobe = cyc;
        end
      end
      if (ack0 || ack1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'({ack1, ack0}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_port", 32'({ack1, ack0}), (e.port == 1) ? 32'd2 : 32'd1);
          check("ack_cycle", cyc, e.ack_cyc);
          check("hold_addr", Address, e.addr);
          check("strobe_len", strobe_cnt, AC);
          check("strobe_end", last_strobe, cyc - 1);
          if (!e.we) begin
            if (e.port == 1) m_rdata1 = e.data;
            else             m_rdata0 = e.data;
          end
          check("rdata0", rdata0, m_rdata0);
          check("rdata1", rdata1, m_rdata1);
          strobe_cnt = 0;
        end
      end
    end
  end

  task automatic load0();
    op_t op;
    if (op_q0.size() > 0) begin
      op = op_q0.pop_front();
      req0 = 1'b1; we0 = op.we; addr0 = op.addr; wdata0 = op.wdata;
    end else begin
      req0 = 1'b0;
    end
  endtask

  task automatic load1();
    op_t op;
    if (op_q1.size() > 0) begin
      op = op_q1.pop_front();
      req1 = 1'b1; we1 = op.we; addr1 = op.addr; wdata1 = op.wdata;
    end else begin
      req1 = 1'b0;
    end
  endtask

  // Both op lists start requesting in the same IDLE cycle; each port keeps req high while it has work.
  task automatic run_phase(input int gap);
    op_t  a0[$], a1[$], op;
    exp_t e;
    int   n, t, p, budget;
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    n  = cyc;
    a0 = op_q0;
    a1 = op_q1;
    t  = n + 2 + AC;
    while (a0.size() > 0 || a1.size() > 0) begin
      if (a0.size() > 0 && a1.size() > 0) p = (m_last == 0) ? 1 : 0;
      else                                p = (a0.size() > 0) ? 0 : 1;
      if (p == 1) op = a1.pop_front();
      else        op = a0.pop_front();
      m_last    = p;
      e.port    = p;
      e.we      = op.we;
      e.addr    = op.addr;
      e.ack_cyc = t;
      if (op.we) begin
        ref_mem[op.addr[5:0]] = op.wdata;
        e.data = op.wdata;
      end else begin
        e.data = ref_mem[op.addr[5:0]];
      end
      exp_q.push_back(e);
      t += AC + 3;
    end
    budget = (op_q0.size() + op_q1.size()) * (AC + 3) + 8;
    load0();
    load1();
    while ((req0 || req1) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (ack0) load0();
      if (ack1) load1();
      if (!req0) begin we0 = 1'($urandom_range(0, 1)); addr0 = $urandom_range(0, 63); wdata0 = $urandom; end
      if (!req1) begin we1 = 1'($urandom_range(0, 1)); addr1 = $urandom_range(0, 63); wdata1 = $urandom; end
    end
    #1;
    check("phase_done", 32'(req0 | req1), 32'd0);
    check("phase_drained", exp_q.size(), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    op_q0.delete(); op_q1.delete(); exp_q.delete();
  endtask

  task automatic rand_ops(input int n0, input int n1);
    op_t op;
    for (int i = 0; i < n0 + n1; i++) begin
      op.we    = 1'($urandom_range(0, 1));
      op.addr  = $urandom_range(0, 15);
      op.wdata = $urandom;
      if (i < n0) op_q0.push_back(op);
      else        op_q1.push_back(op);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, first, rcnt, ackc;
    bit saw;
    reset = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    req3 = 1'b0; addr3 = '0;
    m_last = 1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_a = 6'(i); pre_d = init_val(i);
      ref_mem[i] = init_val(i);
    end
    @(negedge clk);
    pre_we = 1'b0;

    check("rst_memread", 32'(MemRead), 32'd0);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_address", Address, 32'd0);
    check("rst_writedata", WriteData, 32'd0);
    check("rst_acks", 32'({ack1, ack0}), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);

    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    op_q0.push_back('{1'b0, 32'd3, 32'd0});
    run_phase(0);

    op_q1.push_back('{1'b1, 32'd7, 32'hDEAD_BEEF});
    op_q1.push_back('{1'b0, 32'd7, 32'd0});
    run_phase(1);

    rand_ops(4, 4);
    run_phase(0);

    for (int k = 0; k < 12; k++) begin
      rand_ops($urandom_range(0, 3), $urandom_range(0, 3));
      run_phase($urandom_range(0, 2));
    end

    // ACCESS_CYCLES = 3 instance: single read of word 5
    mon_en = 1'b0;
    @(posedge clk); #1;
    n = cyc; req3 = 1'b1; addr3 = 32'd5;
    first = -1; rcnt = 0; ackc = -1;
    for (int k = 0; k < 12 && ackc < 0; k++) begin
      @(negedge clk);
      if (mr3) begin
        if (first < 0) first = cyc;
        rcnt++;
        check("ac3_addr", ad3, 32'd5);
      end
      check("ac3_no_write", 32'({mw3, ack3b}), 32'd0);
      if (ack3a) begin
        ackc = cyc;
        req3 = 1'b0;
      end
    end
    check("ac3_first_strobe", first, n + 2);
    check("ac3_strobe_len", rcnt, 32'd3);
    check("ac3_ack_cycle", ackc, n + 5);
    check("ac3_rdata0", rd3a, init_val(5));
    check("ac3_rdata1", rd3b, 32'd0);
    check("ac3_wdata", wd3, 32'd0);

    // Reset during the strobe cycle of a port-0 write
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd9; wdata0 = 32'hC0FF_EE09;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_strobe", 32'({MemRead, MemWrite}), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    check("midrst_strobes", 32'({MemRead, MemWrite}), 32'd0);
    check("midrst_address", Address, 32'd0);
    check("midrst_writedata", WriteData, 32'd0);
    check("midrst_rdata", rdata0 | rdata1, 32'd0);
    check("midrst_acks", 32'({ack1, ack0}), 32'd0);
    reset = 1'b0;
    ref_mem[9] = 32'hC0FF_EE09;
    m_last = 1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack0 || ack1 || MemRead || MemWrite) saw = 1'b1;
    end
    check("midrst_quiet", 32'(saw), 32'd0);
    mon_en = 1'b1;

    op_q0.push_back('{1'b0, 32'd9, 32'd0});
    op_q1.push_back('{1'b0, 32'd3, 32'd0});
    run_phase(0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
